aes_block_loader: RTL and testbench
===================================

AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed between bytes of a partial block before it is discarded.
REQ-002 clk  in  1  single clock; all logic on posedge clk.
REQ-003 rest  in  1  reset, synchronous, active-high.
REQ-004 byte_in  in  8  incoming ciphertext byte.
REQ-005 byte_valid  in  1  byte_in valid this cycle.
REQ-006 byte_ready  out  1  loader can accept a byte this cycle.
REQ-007 block_out  out  128  assembled ciphertext block, wired to the inverse-AES plaintext1 input.
REQ-008 start  out  1  decryption request to inverse-AES core.
REQ-009 aes_busy  in  1  busy from inverse-AES core.
REQ-010 aes_done  in  1  one-cycle done pulse from inverse-AES core.
REQ-011 byte_count  out  5  bytes held in the current block, 0..16.
REQ-012 block_cnt  out  8  blocks completed by the core since reset.
REQ-013 timeout_err  out  1  one-cycle pulse when a partial block is discarded.

Function
REQ-014 The FSM SHALL have states COLLECT, ISSUE and WAIT_DONE.
REQ-015 byte_ready SHALL be 1 in COLLECT and 0 in ISSUE and WAIT_DONE.
REQ-016 A byte SHALL be accepted on a clock edge where byte_valid and byte_ready are both 1.
REQ-017 Byte k (0-based) SHALL be written to block_out[127-8k -: 8], so the first byte lands in [127:120].
REQ-018 byte_count SHALL increment by 1 per accepted byte.
REQ-019 The edge accepting byte 16 SHALL set byte_count to 16 and move the FSM to ISSUE.
REQ-020 start SHALL be 1 exactly while in ISSUE.
REQ-021 In ISSUE, the first edge with aes_busy=1 SHALL move the FSM to WAIT_DONE, dropping start the following cycle.
REQ-022 In WAIT_DONE, an edge with aes_done=1 SHALL increment block_cnt (255 wraps to 0), clear byte_count to 0 and return to COLLECT.
REQ-023 aes_done or aes_busy seen in COLLECT SHALL be ignored, and aes_done seen in ISSUE SHALL also be ignored.
REQ-024 block_out SHALL be unchanged from acceptance of byte 16 until the next byte is accepted; bytes of a new block overwrite in place.
REQ-025 byte_valid asserted outside COLLECT SHALL have no effect: no byte is lost into, or corrupts, block_out.
REQ-026 Minimum block-to-start latency SHALL be 1 cycle: start is high in the cycle after byte 16 is accepted.

Reset
REQ-027 While rest=1 at a clock edge, the block SHALL go to COLLECT with byte_count=0, block_cnt=0, block_out=0, start=0 and timeout_err=0.
REQ-028 Reset SHALL take priority over every other event, including reset mid-block and reset during ISSUE or WAIT_DONE.
REQ-029 Any outstanding request SHALL be abandoned on reset, and a later aes_done SHALL be ignored.

Configuration
REQ-030 Macro AES_LOADER_TIMEOUT_EN SHALL control the inter-byte timeout feature.
REQ-031 With AES_LOADER_TIMEOUT_EN defined, in COLLECT with byte_count 1..15, an idle counter SHALL count cycles with no accepted byte and reset to 0 on each accepted byte.
REQ-032 With AES_LOADER_TIMEOUT_EN defined, when the idle counter reaches TIMEOUT_CYCLES, byte_count SHALL clear to 0, timeout_err SHALL pulse for 1 cycle, and block_out SHALL be left unchanged.
REQ-033 With AES_LOADER_TIMEOUT_EN defined, a byte accepted on the same edge as the timeout SHALL win: the counter resets and no timeout occurs.
REQ-034 Without AES_LOADER_TIMEOUT_EN, no idle counter SHALL exist, timeout_err SHALL be tied to 0, and a partial block SHALL wait indefinitely.

Verification
REQ-035 Bench SHALL feed bytes 0x00..0x0F back-to-back -> block_out=128'h000102...0F, start=1 one cycle after the last byte, byte_ready=0.
REQ-036 Bench SHALL hold aes_busy=0 for 5 cycles in ISSUE, then raise it -> start stays 1 for those 5 cycles, then WAIT_DONE; aes_done pulse -> block_cnt=1, byte_count=0, byte_ready=1.
REQ-037 Bench SHALL hold byte_valid=1 continuously during WAIT_DONE with changing data -> block_out unchanged until aes_done and the next accepted byte.
REQ-038 Bench SHALL drive 256 complete blocks -> block_cnt returns to 0.
REQ-039 Bench SHALL assert rest after 7 bytes, and separately in WAIT_DONE, then pulse aes_done -> all outputs at reset values, block_cnt stays 0.
REQ-040 With AES_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=10, bench SHALL send 3 bytes then idle -> timeout_err pulses, byte_count=0; a byte arriving exactly on the timeout cycle -> no timeout_err, byte_count=4.

Source files
------------

// File: rtl/aes_block_loader.sv
// Assembles 16 ciphertext bytes into a 128-bit block and hands it to an inverse-AES core.
// Optional inter-byte timeout for partial blocks is enabled by defining AES_LOADER_TIMEOUT_EN.
module aes_block_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         rest,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic [127:0] block_out,
  output logic         start,
  input  logic         aes_busy,
  input  logic         aes_done,
  output logic [4:0]   byte_count,
  output logic [7:0]   block_cnt,
  output logic         timeout_err
);

  typedef enum logic [1:0] {
    COLLECT,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           accept;
  logic           done_evt;
  logic           timeout_hit;
  logic [127:0]   block_next;

  assign byte_ready = (state == COLLECT);
  assign start      = (state == ISSUE);
  assign accept     = byte_valid && byte_ready;
  assign done_evt   = (state == WAIT_DONE) && aes_done;

  always_ff @(posedge clk) begin
    if (rest) state <= COLLECT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT:   if (accept && byte_count == 5'd15) state_next = ISSUE;
      ISSUE:     if (aes_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (aes_done) state_next = COLLECT;
      default:   state_next = COLLECT;
    endcase
  end

  // Byte k lands in the k-th most significant byte lane.
  always_comb begin
    block_next = block_out;
    for (int unsigned i = 0; i < 16; i++) begin
      if (byte_count == 5'(i)) block_next[127 - 8*i -: 8] = byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      block_out  <= '0;
      byte_count <= '0;
      block_cnt  <= '0;
    end else if (accept) begin
      block_out  <= block_next;
      byte_count <= byte_count + 5'd1;
    end else if (done_evt) begin
      byte_count <= '0;
      block_cnt  <= block_cnt + 8'd1;
    end else if (timeout_hit) begin
      byte_count <= '0;
    end
  end

`ifdef AES_LOADER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_armed;

  assign idle_armed  = (state == COLLECT) && (byte_count != 5'd0) && !accept;
  assign timeout_hit = idle_armed && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rest) begin
      idle_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if (idle_armed && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
      else                            idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader: vector table plus hand-written corner sequences.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rest;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic [127:0] block_out;
  logic         start;
  logic         aes_busy;
  logic         aes_done;
  logic [4:0]   byte_count;
  logic [7:0]   block_cnt;
  logic         timeout_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  aes_block_loader #(.TIMEOUT_CYCLES(10)) dut (
    .clk        (clk),
    .rest       (rest),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .block_out  (block_out),
    .start      (start),
    .aes_busy   (aes_busy),
    .aes_done   (aes_done),
    .byte_count (byte_count),
    .block_cnt  (block_cnt),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] din;
    logic       busy;
    logic       done;
    logic       exp_ready;
    logic       exp_start;
    logic [4:0] exp_count;
    logic [7:0] exp_blocks;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic valid, input logic [7:0] din,
                              input logic busy, input logic done, input logic er,
                              input logic es, input logic [4:0] ec, input logic [7:0] eb);
    vec_t v;
    v.rst = rst; v.valid = valid; v.din = din; v.busy = busy; v.done = done;
    v.exp_ready = er; v.exp_start = es; v.exp_count = ec; v.exp_blocks = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rest = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; aes_busy = 1'b0; aes_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      byte_valid = 1'b1;
      byte_in    = base + 8'(k);
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_block();
    aes_busy = 1'b1;
    tick();
    aes_busy = 1'b0;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 128'(byte_ready), 128'(1'b1));
    chk({tag, "_start"}, 128'(start), 128'(1'b0));
    chk({tag, "_count"}, 128'(byte_count), 128'(5'd0));
    chk({tag, "_blocks"}, 128'(block_cnt), 128'(8'd0));
    chk({tag, "_block"}, block_out, 128'h0);
    chk({tag, "_terr"}, 128'(timeout_err), 128'(1'b0));
  endtask

  initial begin
    idle_inputs();
    rest = 1'b1;

    // Reset, ignored core handshakes, one full block, 5-cycle busy stall, then done.
    add(1, 0, 8'h00, 0, 0, 1, 0, 5'd0, 8'd0);
    add(0, 0, 8'h00, 1, 1, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < 16; k++)
      add(0, 1, 8'(k), 0, 0, (k < 15), (k == 15), 5'(k + 1), 8'd0);
    for (int k = 0; k < 5; k++)
      add(0, 1, 8'hA0 + 8'(k), 0, (k == 2), 0, 1, 5'd16, 8'd0);
    add(0, 1, 8'hB0, 1, 0, 0, 0, 5'd16, 8'd0);
    for (int k = 0; k < 3; k++)
      add(0, 1, 8'hC0 + 8'(k), (k != 1), 0, 0, 0, 5'd16, 8'd0);
    add(0, 1, 8'hD0, 0, 1, 1, 0, 5'd0, 8'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      rest = vecs[i].rst; byte_valid = vecs[i].valid; byte_in = vecs[i].din;
      aes_busy = vecs[i].busy; aes_done = vecs[i].done;
      tick();
      chk($sformatf("v%0d_ready", i), 128'(byte_ready), 128'(vecs[i].exp_ready));
      chk($sformatf("v%0d_start", i), 128'(start), 128'(vecs[i].exp_start));
      chk($sformatf("v%0d_count", i), 128'(byte_count), 128'(vecs[i].exp_count));
      chk($sformatf("v%0d_blocks", i), 128'(block_cnt), 128'(vecs[i].exp_blocks));
      chk($sformatf("v%0d_terr", i), 128'(timeout_err), 128'(1'b0));
    end
    idle_inputs();
    chk("block_hold_after_done", block_out, 128'h000102030405060708090A0B0C0D0E0F);

    // First byte of the next block overwrites lane 0 only.
    send_bytes(8'hEE, 1);
    chk("overwrite_first", block_out, 128'hEE0102030405060708090A0B0C0D0E0F);
    chk("overwrite_count", 128'(byte_count), 128'(5'd1));
    send_bytes(8'h11, 15);
    chk("block2_data", block_out, 128'hEE1112131415161718191A1B1C1D1E1F);
    chk("block2_start", 128'(start), 128'(1'b1));
    finish_block();
    chk("block2_cnt", 128'(block_cnt), 128'(8'd2));

    // Wrap of the completed-block counter.
    for (int b = 2; b < 255; b++) begin
      send_bytes(8'(b), 16);
      finish_block();
    end
    chk("cnt_255", 128'(block_cnt), 128'(8'd255));
    send_bytes(8'h40, 16);
    finish_block();
    chk("cnt_wrap", 128'(block_cnt), 128'(8'd0));
    chk("wrap_ready", 128'(byte_ready), 128'(1'b1));

    // Reset mid-block after one completed block.
    send_bytes(8'h60, 16);
    finish_block();
    chk("pre_rst_cnt", 128'(block_cnt), 128'(8'd1));
    send_bytes(8'h70, 7);
    chk("mid_count", 128'(byte_count), 128'(5'd7));
    rest = 1'b1;
    tick();
    rest = 1'b0;
    chk_reset_state("rst_mid");

    // Reset during ISSUE.
    send_bytes(8'h80, 16);
    chk("issue_start", 128'(start), 128'(1'b1));
    rest = 1'b1;
    tick();
    rest = 1'b0;
    chk_reset_state("rst_issue");

    // Reset during WAIT_DONE, then a stale done pulse.
    send_bytes(8'h90, 16);
    aes_busy = 1'b1;
    tick();
    aes_busy = 1'b0;
    chk("wait_start", 128'(start), 128'(1'b0));
    chk("wait_ready", 128'(byte_ready), 128'(1'b0));
    rest = 1'b1;
    tick();
    rest = 1'b0;
    aes_done = 1'b1;
    tick();
    aes_done = 1'b0;
    chk_reset_state("rst_wait");

`ifdef AES_LOADER_TIMEOUT_EN
    send_bytes(8'hA0, 3);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("to_err_%0d", i), 128'(timeout_err), 128'(i == 10));
      chk($sformatf("to_count_%0d", i), 128'(byte_count), (i == 10) ? 128'd0 : 128'd3);
    end
    tick();
    chk("to_pulse_end", 128'(timeout_err), 128'(1'b0));
    chk("to_block_kept", block_out, {8'hA0, 8'hA1, 8'hA2, 104'h0});
    send_bytes(8'hB0, 3);
    for (int i = 1; i <= 9; i++) tick();
    chk("edge_count_pre", 128'(byte_count), 128'(5'd3));
    send_bytes(8'hB3, 1);
    chk("edge_err", 128'(timeout_err), 128'(1'b0));
    chk("edge_count", 128'(byte_count), 128'(5'd4));
    tick();
    chk("edge_err_after", 128'(timeout_err), 128'(1'b0));
    chk("edge_block", block_out, {8'hB0, 8'hB1, 8'hB2, 8'hB3, 96'h0});
`else
    send_bytes(8'hA0, 3);
    begin
      logic seen_err;
      seen_err = 1'b0;
      for (int i = 0; i < 30; i++) begin
        tick();
        if (timeout_err !== 1'b0) seen_err = 1'b1;
      end
      chk("no_to_err", 128'(seen_err), 128'(1'b0));
    end
    chk("no_to_count", 128'(byte_count), 128'(5'd3));
    chk("no_to_block", block_out, {8'hA0, 8'hA1, 8'hA2, 104'h0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
